// File: rtl/msg_ram_pkg.sv
// Shared definitions for the message RAM, its loader and its sequential reader.
package msg_ram_pkg;

    localparam int unsigned MSG_WIDTH  = 16;
    localparam int unsigned MEM_HEIGHT = 32;
    localparam int unsigned ADDR       = 5;

    // Loader/reader control states; encoding is shared with the reader side.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } ram_state_e;

endpackage

// File: rtl/msg_ram_csum.sv
// Running modulo-2^width sum of accepted message words.
// Only present when LOADER_CHECKSUM_EN is defined.
`ifdef LOADER_CHECKSUM_EN
module msg_ram_csum #(
    parameter int unsigned width = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             accept,
    input  logic [width-1:0] data,
    output logic [width-1:0] csum
);

    // Accumulate on every accepted word; cleared when a new load starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum <= '0;
        end else if (clear) begin
            csum <= '0;
        end else if (accept) begin
            csum <= csum + data;
        end
    end

endmodule
`endif

// File: rtl/msg_ram_loader.sv
// Write-side companion of the message RAM: takes a valid/ready stream of
// messages and writes them to sequential RAM addresses starting at 0.
// Optional LOADER_CHECKSUM_EN adds a csum output summing accepted words.
module msg_ram_loader
    import msg_ram_pkg::*;
#(
    parameter int unsigned msg_width  = MSG_WIDTH,
    parameter int unsigned mem_height = MEM_HEIGHT,
    parameter int unsigned addr       = ADDR
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 s_valid,
    input  logic [msg_width-1:0] s_data,
    input  logic                 s_last,
    output logic                 s_ready,
    output logic                 we,
    output logic [addr-1:0]      w_addr,
    output logic [msg_width-1:0] data_in,
    output logic                 busy,
    output logic                 done,
    output logic [addr:0]        count,
    output logic                 full
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [msg_width-1:0] csum
`endif
);

    // Last legal address; compared explicitly so non-power-of-2 depths work.
    localparam logic [addr-1:0] LAST_PTR = addr'(mem_height - 1);

    ram_state_e      state;
    ram_state_e      state_nx;
    logic [addr-1:0] ptr;
    logic            accept;
    logic            load_start;
    logic            at_end;

    // Handshake and event decode shared by the FSM and datapath.
    assign s_ready    = (state == LOAD);
    assign busy       = (state == LOAD);
    assign accept     = s_valid & s_ready;
    assign load_start = (state == IDLE) & start;
    assign at_end     = (ptr == LAST_PTR);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: a frame ends on s_last or when the RAM is full.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                if (accept && (s_last || at_end)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Write port, pointer, counters and completion flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr     <= '0;
            we      <= 1'b0;
            w_addr  <= '0;
            data_in <= '0;
            done    <= 1'b0;
            count   <= '0;
            full    <= 1'b0;
        end else begin
            we   <= accept;
            done <= (state == DONE);
            if (load_start) begin
                ptr   <= '0;
                count <= '0;
                full  <= 1'b0;
            end
            if (accept) begin
                w_addr  <= ptr;
                data_in <= s_data;
                count   <= count + (addr + 1)'(1);
                if (at_end) begin
                    full <= 1'b1;
                end else begin
                    ptr <= ptr + addr'(1);
                end
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Checksum of the words accepted in the current/last load.
    msg_ram_csum #(
        .width (msg_width)
    ) u_csum (
        .clk    (clk),
        .rst    (rst),
        .clear  (load_start),
        .accept (accept),
        .data   (s_data),
        .csum   (csum)
    );
`endif

endmodule
